// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_pkg
// Description : Shared UART transmit definitions. Holds the frame FSM state
//               encoding, the minimum bit-period divider and a divider
//               clamp helper. The matching receiver can use the same values.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [31:0] UART_MIN_DIV = 32'd2;

  // The bit counter needs at least two clocks per bit, so 0 and 1 are
  // treated as 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < UART_MIN_DIV) ? UART_MIN_DIV : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_buf
// Description : Synchronous 8-bit FIFO, 2**FIFO_AW entries, with
//               first-word-fall-through read data.
// Ports       : clk, reset_n    - clock, synchronous active-low reset
//               push, wdata     - write strobe and data (ignored when full)
//               pop, rdata      - read strobe (ignored when empty), head data
//               level           - occupancy 0..2**FIFO_AW
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_buf #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [7:0]         wdata,
  input  logic               pop,
  output logic [7:0]         rdata,
  output logic [FIFO_AW:0]   level,
  output logic               full,
  output logic               empty
);

  localparam int              c_depth_int = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] c_depth    = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         r_mem [c_depth_int];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_level == c_depth);
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign rdata  = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers are FIFO_AW bits wide, so they wrap modulo depth on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter, 8N1 framing (8E1 when the
//               UART_TX_PARITY_EN macro is defined), LSB first, with a
//               2**FIFO_AW byte FIFO in front of the frame FSM.
// Ports       : clk, reset_n  - clock, synchronous active-low reset
//               cfg_divider   - clocks per bit, sampled when a byte is popped
//               data, valid   - byte offered, accepted when valid && ready
//               ready         - FIFO not full
//               ser_tx        - serial line, idle high
//               busy          - frame in progress or FIFO non-empty
//               level         - FIFO occupancy
// Config      : UART_TX_PARITY_EN - adds an even-parity bit after the data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        cfg_divider,
  input  logic [7:0]         data,
  input  logic               valid,
  output logic               ready,
  output logic               ser_tx,
  output logic               busy,
  output logic [FIFO_AW:0]   level
);

  tx_state_t   r_state;
  tx_state_t   w_next_state;
  logic [31:0] r_div;
  logic [31:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        w_pop;
  logic        w_bit_end;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_head;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  uart_tx_fifo_buf #(
    .FIFO_AW (FIFO_AW)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (valid),
    .wdata   (data),
    .pop     (w_pop),
    .rdata   (w_head),
    .level   (level),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign ready     = !w_full;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign w_bit_end = (r_cnt == r_div - 32'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state, FIFO pop and line level.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    ser_tx       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        ser_tx = 1'b0;
        if (w_bit_end) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        ser_tx = r_shift[0];
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        ser_tx = r_parity;
        if (w_bit_end) w_next_state = ST_STOP;
`else
        w_next_state = ST_IDLE;
`endif
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Bit-period counter and shift register. A pop restarts the frame and
  // latches the divider, so divider changes only affect later frames.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div     <= UART_MIN_DIV;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_pop) begin
      r_div     <= clamp_div(cfg_divider);
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
      r_parity  <= ^w_head;
`endif
    end else if (r_state != ST_IDLE) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        if (r_state == ST_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A queue-based frame
//               model predicts ser_tx/level/ready/busy every cycle; directed
//               tests add literal expectations. Honors UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [31:0] cfg_divider = 32'd4;
  logic        ready;
  logic        ser_tx;
  logic        busy;
  logic [AW:0] level;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_fifo #(.FIFO_AW(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_divider (cfg_divider),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .ser_tx      (ser_tx),
    .busy        (busy),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit         m_ok = 1'b0;
  bit         m_active = 1'b0;
  int         m_t = 0;
  int         m_div = 2;
  logic [7:0] m_byte = 8'h00;

  function automatic int clampd(input logic [31:0] d);
    return (d < 32'd2) ? 2 : int'(d);
  endfunction

  function automatic logic exp_line();
    int i;
    if (!m_active) return 1'b1;
    i = m_t / m_div;
    if (i == 0) return 1'b0;
    if (i <= 8) return m_byte[i-1];
    if (NB == 11 && i == 9) return ^m_byte;
    return 1'b1;
  endfunction

  task automatic m_start();
    m_byte   = mq.pop_front();
    m_div    = clampd(cfg_divider);
    m_t      = 0;
    m_active = 1'b1;
  endtask

  always @(posedge clk) begin : m_blk
    bit acc;
    acc  = valid && (mq.size() < DEPTH);
    m_ok = 1'b1;
    if (!reset_n) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      if (m_active) begin
        if (m_t == NB * m_div - 1) begin
          m_active = 1'b0;
          if (mq.size() > 0) m_start();
        end else begin
          m_t++;
        end
      end else if (mq.size() > 0) begin
        m_start();
      end
      if (acc) mq.push_back(data);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("ser_tx", ser_tx, exp_line());
      chk("level", level, mq.size());
      chk("ready", ready, mq.size() < DEPTH);
      chk("busy", busy, m_active || (mq.size() > 0));
    end
  end

  // ---------------- helpers ----------------
  bit line_q[$];

  task automatic push(input logic [7:0] b);
    bit acc;
    int g;
    g = 0;
    acc = 1'b0;
    data  = b;
    valid = 1'b1;
    do begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 1000);
    valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture(input int n);
    line_q.delete();
    repeat (n) begin
      @(negedge clk);
      line_q.push_back(ser_tx);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy !== 1'b0 || m_active) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp3 [3];
    logic [7:0] dec;
    int s, base, zeros, g;
    exp3[0] = 8'h41; exp3[1] = 8'h0D; exp3[2] = 8'hFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ser_tx", ser_tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single byte 0x55, div 4: idle at N+1, start bit from N+2.
    cfg_divider = 32'd4;
    push(8'h55);
    capture(NB * 4 + 3);
    chk("lat_n1_idle", line_q[0], 1);
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk("b55_bit", line_q[1 + i*4 + j],
            (i == NB-1) ? 1 : (i == 9) ? 0 : (i % 2));
      end
    end
    chk("b55_busy_end", busy, 0);
    wait_idle();

    // Three back-to-back bytes at div 8, decoded from the line.
    cfg_divider = 32'd8;
    push(8'h41); push(8'h0D); push(8'hFF);
    capture(3 * NB * 8 + 10);
    s = 0;
    while (s < line_q.size() && line_q[s] != 1'b0) s++;
    for (int k = 0; k < 3; k++) begin
      base = s + k * NB * 8;
      dec = 8'h00;
      chk("dec_start", line_q[base + 4], 0);
      for (int i = 0; i < 8; i++) dec[i] = line_q[base + (1+i)*8 + 4];
      chk("dec_byte", dec, exp3[k]);
      chk("dec_stop", line_q[base + (NB-1)*8 + 4], 1);
    end
    wait_idle();

    // Fill to 16 while a frame runs; cfg_divider=1 clamps to 2.
    cfg_divider = 32'd1;
    push(8'h00);
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    @(negedge clk);
    chk("full_level", level, 16);
    chk("full_ready", ready, 0);
    push(8'hEE);
    @(negedge clk);
    chk("refill_level", level, 16);
    wait_idle();

    // cfg_divider=0 also clamps to 2.
    cfg_divider = 32'd0;
    push(8'hA3);
    capture(5);
    chk("div0_idle", line_q[0], 1);
    chk("div0_start0", line_q[1], 0);
    chk("div0_start1", line_q[2], 0);
    chk("div0_d0", line_q[3], 1);
    chk("div0_d0b", line_q[4], 1);
    wait_idle();

    // Divider change mid-frame only affects the next frame.
    cfg_divider = 32'd4;
    push(8'h12); push(8'h34);
    repeat (10) @(negedge clk);
    chk("div_cur", m_div, 4);
    cfg_divider = 32'd6;
    g = 0;
    while (!(m_active && m_byte == 8'h34) && g < 200) begin @(negedge clk); g++; end
    chk("div_next", m_div, 6);
    wait_idle();

    // Reset during data bit 3 aborts the frame and drops queued bytes.
    cfg_divider = 32'd4;
    push(8'hA5); push(8'h3C); push(8'h0F);
    g = 0;
    while (!(m_active && m_t / m_div == 4) && g < 200) begin @(negedge clk); g++; end
    chk("rst_mid_reached", g < 200, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ser_tx", ser_tx, 1);
    chk("rst_mid_level", level, 0);
    capture(60);
    zeros = 0;
    foreach (line_q[i]) if (line_q[i] == 1'b0) zeros++;
    chk("rst_no_restart", zeros, 0);

`ifdef UART_TX_PARITY_EN
    // Byte 0x07 has odd weight, so the even-parity bit is 1.
    cfg_divider = 32'd3;
    push(8'h07);
    capture(NB * 3 + 3);
    chk("par_d7", line_q[1 + 8*3 + 1], 0);
    chk("par_bit", line_q[1 + 9*3 + 1], 1);
    chk("par_stop", line_q[1 + 10*3 + 1], 1);
    wait_idle();
`endif

    // Randomized traffic with occasional divider changes and resets.
    @(posedge clk); #1;
    for (int c = 0; c < 1500; c++) begin
      valid = ($urandom % 4 == 0);
      data  = 8'($urandom);
      if ($urandom % 200 == 0) cfg_divider = $urandom_range(0, 5);
      reset_n = ($urandom % 500 != 0);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    reset_n = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
